fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin write-port arbiter and sequencer for the 4-bit CDC FIFO write side. Up to NUM_REQ requesters in the write-clock domain share the single FIFO write port through valid/ready handshakes. The block grants one requester at a time for bounded bursts, honours `full`, and generates a synchronised write reset for the FIFO. It sits between the requesters and the FIFO write interface, with FIFO `write_clock` tied to `clk`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 4: FIFO word width.
- `MAX_BURST`, 4: maximum transfers per grant, ≥1.

- `clk` input 1: write-domain clock; also drives FIFO `write_clock`.
- `rst_n` input 1: asynchronous reset, active low.
- `req_valid` input NUM_REQ: per-requester valid.
- `req_data` input NUM_REQ*DATA_WIDTH: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready` output NUM_REQ: per-requester ready, one-hot or zero.
- `fifo_full` input 1: FIFO `full` flag.
- `fifo_write_data` output DATA_WIDTH: to FIFO `write_data`.
- `fifo_write_increment` output 1: to FIFO `write_increment`.
- `fifo_write_reset` output 1: active-high FIFO write reset.
- `grant_valid` output 1: a requester currently holds the grant.
- `grant_id` output clog2(NUM_REQ): index of the granted requester.
- `xfer_count` output 8: total accepted words, wraps 255→0.

## Operation
- FSM states:
  - RESET_SYNC: on `rst_n` low, asynchronously enter RESET_SYNC with `fifo_write_reset`=1. Hold for 2 `clk` edges after `rst_n` rises, then go to IDLE. The reset is asserted asynchronously and released synchronously.
  - IDLE: `grant_valid`=0 and all `req_ready`=0. If any `req_valid` is high, choose the first valid index scanning from `last_grant+1` modulo NUM_REQ. Register it into `grant_id`, clear `burst_cnt`, and go to BURST.
  - BURST: `req_ready[grant_id]` = !`fifo_full`. A transfer occurs when `req_valid[grant_id]` && `req_ready[grant_id]`.
- Datapath:
  - `fifo_write_data` = `req_data[grant_id]`, combinational.
  - `fifo_write_increment` = transfer, combinational. It is never high when `fifo_full`=1.
  - Each transfer increments `burst_cnt` and `xfer_count`.
- Exits from BURST to IDLE, setting `last_grant` = `grant_id`:
  - `req_valid[grant_id]` low in BURST.
  - A transfer that makes `burst_cnt` reach MAX_BURST.
- Stall: while `fifo_full`=1 in BURST, hold the grant with no timeout. Stall cycles do not count toward the burst.
- Handshake rule: once a requester raises valid, it keeps valid high and data stable until its ready is seen high. Deasserting valid early ends the grant and is not an error.
- Reset values:
  - `req_ready`=0, `fifo_write_increment`=0.
  - `fifo_write_data`=`req_data[0]`; don't-care, bench must not check.
  - `grant_valid`=0, `grant_id`=0, `xfer_count`=0, `fifo_write_reset`=1.
  - `last_grant`=NUM_REQ-1, so requester 0 wins first.

## Timing
- Arbitration: a request in IDLE at edge N gives a grant visible after edge N; the first transfer is possible in the cycle N..N+1.
- There is exactly one idle cycle between consecutive bursts, even when requests are pending.
- Throughput: 1 word/cycle within a burst. With all requesters saturated, peak is MAX_BURST/(MAX_BURST+1) words/cycle.
- `fifo_full` to `req_ready` is combinational, zero latency. `fifo_full` rising in a cycle blocks that cycle's transfer.
- `rst_n` asserted mid-burst: all outputs return to reset values immediately and no further increment occurs. The in-flight FIFO word count is the FIFO's concern.
- `xfer_count` wraps silently.

## Structure
- Shared package `cdc_fifo_pkg`:
  - FSM state enum: RESET_SYNC, IDLE, BURST.
  - Default width constants: DATA_WIDTH=4, address width 5.
  - Reset sync depth constant = 2.
- One sub-module, `rr_pick`: a combinational round-robin priority selector taking the valid vector and last grant, and returning the index plus an any-valid flag.
- The reset synchronizer stays inline.

## Test plan
- Reset: hold `rst_n`=0 and check the reset values. Release and check `fifo_write_reset` falls after exactly 2 `clk` edges, then IDLE.
- Single requester, 6 words: with `req_valid[2]` held, MAX_BURST=4 → words 0–3 in 4 consecutive cycles, 1 idle cycle, regrant to 2, words 4–5. `xfer_count`=6.
- All 4 requesters saturated: grant order 0,1,2,3,0,… with 4 words each and one idle cycle between bursts. `fifo_write_increment` is never high on two grants in the same cycle.
- `fifo_full` pulse for 3 cycles mid-burst → `req_ready` and `fifo_write_increment` both 0 for those 3 cycles. The grant is held, and `burst_cnt` resumes so the burst still delivers exactly 4 words.
- Requester 1 drops valid after 2 words → IDLE next cycle, then requester 2 is granted while requester 1 waits its turn.
- `rst_n` pulsed low during a burst at word 2 → `fifo_write_increment` goes low immediately and `xfer_count`=0. After the resync, the first grant goes to requester 0.

Source files
------------

// File: rtl/cdc_fifo_pkg.sv
// cdc_fifo_pkg: shared FSM type and default widths for the CDC FIFO write side
package cdc_fifo_pkg;
  typedef enum logic [1:0] {RESET_SYNC, IDLE, BURST} state_e;
  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int RST_SYNC_DEPTH = 2;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first valid index after i_last
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_valid,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_idx,
  output logic         o_any
);
  logic [W-1:0] w_j;
  always_comb begin
    o_idx = '0;
    o_any = |i_valid;
    w_j = '0;
    for (int k = N; k >= 1; k--) begin
      w_j = W'((int'(i_last) + k) % N);
      if (i_valid[w_j]) o_idx = w_j;
    end
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter and reset sequencer for the FIFO write port
module fifo_write_arbiter
  import cdc_fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  output logic                          fifo_write_increment,
  output logic                          fifo_write_reset,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [7:0]                    xfer_count
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  state_e                r_state;
  logic [1:0]            r_sync_cnt;
  logic [IW-1:0]         r_grant_id;
  logic [IW-1:0]         r_last;
  logic [BW-1:0]         r_burst;
  logic [7:0]            r_xfer_count;
  logic [DATA_WIDTH-1:0] w_words [NUM_REQ];
  logic [IW-1:0]         w_pick;
  logic                  w_any;
  logic                  w_busy;
  logic                  w_xfer;
  logic                  w_last_word;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign w_words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  rr_pick #(.N(NUM_REQ), .W(IW)) u_pick (
    .i_valid(req_valid),
    .i_last (r_last),
    .o_idx  (w_pick),
    .o_any  (w_any)
  );
  always_comb begin
    w_busy      = r_state == BURST;
    w_xfer      = w_busy && req_valid[r_grant_id] && !fifo_full;
    w_last_word = w_xfer && r_burst == BW'(MAX_BURST - 1);
    req_ready   = (w_busy && !fifo_full) ? NUM_REQ'(1) << r_grant_id : '0;
  end
  assign fifo_write_data      = w_words[r_grant_id];
  assign fifo_write_increment = w_xfer;
  assign fifo_write_reset     = r_state == RESET_SYNC;
  assign grant_valid          = w_busy;
  assign grant_id             = r_grant_id;
  assign xfer_count           = r_xfer_count;
  // reset enters asynchronously; leaving RESET_SYNC waits RST_SYNC_DEPTH clean edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RESET_SYNC;
      r_sync_cnt   <= '0;
      r_grant_id   <= '0;
      r_last       <= IW'(NUM_REQ - 1);
      r_burst      <= '0;
      r_xfer_count <= '0;
    end else begin
      if (w_xfer) begin
        r_burst      <= r_burst + BW'(1);
        r_xfer_count <= r_xfer_count + 8'd1;
      end
      if (r_state == RESET_SYNC) begin
        r_sync_cnt <= r_sync_cnt + 2'd1;
        if (r_sync_cnt == 2'(RST_SYNC_DEPTH - 1)) r_state <= IDLE;
      end else if (r_state == IDLE) begin
        if (w_any) begin
          r_state    <= BURST;
          r_grant_id <= w_pick;
          r_burst    <= '0;
        end
      end else if (!req_valid[r_grant_id] || w_last_word) begin
        r_state <= IDLE;
        r_last  <= r_grant_id;
      end
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: randomized requesters against a queue-based arbitration model
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int MB = 4;
  localparam int IW = $clog2(N);
  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [7:0]    cnt;
  } exp_t;
  logic            clk = 0;
  logic            rst_n = 0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            fifo_full = 0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   fifo_write_data;
  logic            fifo_write_increment;
  logic            fifo_write_reset;
  logic            grant_valid;
  logic [IW-1:0]   grant_id;
  logic [7:0]      xfer_count;
  exp_t            q[$];
  int              passed = 0;
  int              total = 0;
  bit              chk_en = 0;
  bit              e_gv;
  int              e_gid;
  logic [N-1:0]    e_ready;
  bit              m_busy;
  int              m_id;
  int              m_last;
  int              m_n;
  logic [7:0]      m_cnt;
  bit              m_xfer;
  int              m_xid;
  always #5 clk = ~clk;
  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid           (req_valid),
    .req_data            (req_data),
    .req_ready           (req_ready),
    .fifo_full           (fifo_full),
    .fifo_write_data     (fifo_write_data),
    .fifo_write_increment(fifo_write_increment),
    .fifo_write_reset    (fifo_write_reset),
    .grant_valid         (grant_valid),
    .grant_id            (grant_id),
    .xfer_count          (xfer_count)
  );
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  // one cycle of the reference: who owns the port, whether a word moves, who is next
  task automatic model_step();
    bit x;
    e_gv    = m_busy;
    e_gid   = m_id;
    e_ready = (m_busy && !fifo_full) ? N'(1) << m_id : '0;
    x = m_busy && req_valid[m_id] && !fifo_full;
    if (x) begin
      q.push_back(exp_t'{IW'(m_id), req_data[m_id*DW +: DW], m_cnt});
      m_cnt++;
    end
    m_xfer = x;
    m_xid  = m_id;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++)
        if (req_valid[(m_last + k) % N]) begin
          m_id = (m_last + k) % N;
          m_busy = 1;
          m_n = 0;
          break;
        end
    end else if (!req_valid[m_id]) begin
      m_busy = 0;
      m_last = m_id;
    end else if (x) begin
      m_n++;
      if (m_n == MB) begin
        m_busy = 0;
        m_last = m_id;
      end
    end
  endtask
  task automatic drive(input logic [N-1:0] vmask, input int pv, input int pf, input int pd);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i]) begin
        if (m_xfer && m_xid == i) begin
          req_valid[i] = vmask[i] && ($urandom_range(99) < pv);
          req_data[i*DW +: DW] = DW'($urandom);
        end else if ($urandom_range(99) < pd) req_valid[i] = 0;
      end else begin
        req_valid[i] = vmask[i] && ($urandom_range(99) < pv);
        req_data[i*DW +: DW] = DW'($urandom);
      end
    end
    fifo_full = $urandom_range(99) < pf;
    model_step();
  endtask
  task automatic do_reset();
    int edges;
    chk_en = 0;
    rst_n = 0;
    req_valid = '0;
    fifo_full = 0;
    q.delete();
    m_busy = 0; m_id = 0; m_last = N - 1; m_n = 0; m_cnt = 0; m_xfer = 0; m_xid = 0;
    e_gv = 0; e_gid = 0; e_ready = '0;
    #1;
    check("rst_write_reset", int'(fifo_write_reset), 1);
    check("rst_incr", int'(fifo_write_increment), 0);
    check("rst_grant_valid", int'(grant_valid), 0);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_xfer_count", int'(xfer_count), 0);
    check("rst_grant_id", int'(grant_id), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    edges = 0;
    while (fifo_write_reset && edges < 10) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("reset_release_edges", edges, 2);
    check("post_reset_grant_valid", int'(grant_valid), 0);
    chk_en = 1;
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      check("grant_valid", int'(grant_valid), int'(e_gv));
      if (e_gv) check("grant_id", int'(grant_id), e_gid);
      check("req_ready", int'(req_ready), int'(e_ready));
      check("incr_while_full", int'(fifo_write_increment && fifo_full), 0);
      check("write_reset", int'(fifo_write_reset), 0);
      check("incr", int'(fifo_write_increment), int'(q.size() != 0));
      if (q.size() != 0) begin
        e = q.pop_front();
        if (fifo_write_increment) begin
          check("write_data", int'(fifo_write_data), int'(e.data));
          check("write_owner", int'(grant_id), int'(e.id));
          check("xfer_count", int'(xfer_count), int'(e.cnt));
        end
      end
    end
  end
  initial begin
    do_reset();
    repeat (8) drive(4'b0100, 100, 0, 0);
    drive(4'b0000, 0, 0, 0);
    @(negedge clk);
    #1 check("single_req_total", int'(xfer_count), 6);
    repeat (45) drive('1, 100, 0, 0);
    repeat (400) drive('1, 60, 25, 5);
    repeat (200) drive(4'b1010, 80, 10, 3);
    do_reset();
    repeat (4) drive('1, 100, 0, 0);
    #2 check("mid_burst_incr_before", int'(fifo_write_increment), 1);
    chk_en = 0;
    rst_n = 0;
    #1;
    check("mid_burst_incr_after", int'(fifo_write_increment), 0);
    check("mid_burst_xfer_count", int'(xfer_count), 0);
    check("mid_burst_write_reset", int'(fifo_write_reset), 1);
    check("mid_burst_grant_valid", int'(grant_valid), 0);
    do_reset();
    repeat (2) drive('1, 100, 0, 0);
    check("first_grant_after_reset", int'(grant_id), 0);
    check("first_grant_valid", int'(grant_valid), 1);
    repeat (20) drive('1, 100, 20, 0);
    @(negedge clk);
    #1 $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
